ex_muldiv_ctrl: RTL

//  Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner for step_ex.

---
 rtl/ex_muldiv_ctrl_pkg.sv | 29 ++
 rtl/ex_muldiv_ctrl_div_iter.sv | 44 ++++
 rtl/ex_muldiv_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and sizing for the EX-stage multiply/divide sequencer.
// Includes a small helper that takes the magnitude of a two's-complement operand.
package ex_muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_BUSY = 2'd1,
    MD_STATE_DONE = 2'd2
  } md_state_e;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 6;

  // Signed ops work on magnitudes; the result signs are restored after the fact.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_div_iter.sv
// Radix-2 restoring divider core: one quotient bit per step on unsigned magnitudes.
// o_quot/o_rem show the result of the step taken in the current cycle.
module ex_muldiv_ctrl_div_iter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_shift = {r_rem, r_quot[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_fits  = ~w_diff[32];

  // Exposing the post-step value lets the owner commit on the same edge as the final step.
  assign o_quot = {r_quot[30:0], w_fits};
  assign o_rem  = w_fits ? w_diff[31:0] : w_shift[31:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_quot    <= i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_quot <= o_quot;
      r_rem  <= o_rem;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner beside the EX stage.
// Stalls the pipeline while an op runs, commits {hi,lo}, and services MTHI/MTLO.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mag_a;
  logic [31:0]      r_mag_b;
  logic [31:0]      r_raw_a;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;
  logic             r_done;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_idle_ok;
  logic        w_start;
  logic        w_div_step;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;
  logic [63:0] w_commit;

  assign w_is_mul = (i_op == MD_OP_MULT) || (i_op == MD_OP_MULTU);
  assign w_is_div = (i_op == MD_OP_DIV)  || (i_op == MD_OP_DIVU);
  assign w_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);

  // Gating with i_rst_n keeps stall low while reset is asserted, even with an op held.
  assign w_idle_ok  = i_rst_n && (r_state == MD_STATE_IDLE) && i_op_valid && !i_flush;
  assign w_start    = w_idle_ok && (w_is_mul || w_is_div);
  assign w_div_step = (r_state == MD_STATE_BUSY) && r_is_div;

  assign w_mag_a = mag_of(i_src_a, w_signed);
  assign w_mag_b = mag_of(i_src_b, w_signed);

  ex_muldiv_ctrl_div_iter u_div_iter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_start && w_is_div),
    .i_step     (w_div_step),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_prod_mag = {32'd0, r_mag_a} * {32'd0, r_mag_b};
  assign w_prod     = r_neg_q ? (64'd0 - w_prod_mag) : w_prod_mag;
  assign w_q_fix    = r_neg_q ? (32'd0 - w_quot) : w_quot;
  assign w_r_fix    = r_neg_r ? (32'd0 - w_rem)  : w_rem;
  assign w_commit   = !r_is_div  ? w_prod :
                      r_div_zero ? {r_raw_a, 32'hFFFF_FFFF} :
                                   {w_r_fix, w_q_fix};

  assign o_stall = w_start || ((r_state == MD_STATE_BUSY) && !i_flush);
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= MD_STATE_IDLE;
      r_cnt      <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_raw_a    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        MD_STATE_IDLE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            r_raw_a    <= i_src_a;
            r_is_div   <= w_is_div;
            r_neg_q    <= w_signed && (i_src_a[31] ^ i_src_b[31]);
            r_neg_r    <= w_signed && i_src_a[31];
            r_div_zero <= (i_src_b == 32'd0);
            r_cnt      <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            r_busy     <= 1'b1;
            r_state    <= MD_STATE_BUSY;
          end else if (w_idle_ok && (i_op == MD_OP_MTHI)) begin
            r_hi <= i_src_a;
          end else if (w_idle_ok && (i_op == MD_OP_MTLO)) begin
            r_lo <= i_src_a;
          end
        end
        MD_STATE_BUSY: begin
          if (i_flush) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= MD_STATE_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              {r_hi, r_lo} <= w_commit;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= MD_STATE_DONE;
            end
          end
        end
        MD_STATE_DONE: begin
          r_done  <= 1'b0;
          r_state <= MD_STATE_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= MD_STATE_IDLE;
        end
      endcase
    end
  end

endmodule
